// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module     : shift_pkg
// Description: Shared definitions for the 64-bit shift sequencer and the
//              32-bit barrel shifter it drives. Contains the shifter op
//              encodings, the sequencer state encoding and the 32-bit
//              all-ones constant.
// Revision   : 1.0 - initial release
// ============================================================================
package shift_pkg;

  // Shifter op encodings (shared by the 64-bit request port and the 32-bit core)
  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  localparam logic [31:0] ALL_ONES_32 = 32'hFFFF_FFFF;

  // Sequencer states: one shifter pass per PM/PA/PB state
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PM   = 3'd1,
    S_PA   = 3'd2,
    S_PB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift64_ctrl_barrel32.sv
`default_nettype none
// ============================================================================
// Module     : shift64_ctrl_barrel32
// Description: 32-bit combinational barrel shifter, op-encoded.
//              SLL / SRL / SRA / ROR by a 5-bit amount.
// Ports      : data   [31:0] in  - operand
//              op     [1:0]  in  - SHIFT_SLL/SRL/SRA/ROR
//              amount [4:0]  in  - shift/rotate distance 0..31
//              result [31:0] out - shifted operand
// Revision   : 1.0 - initial release
// ============================================================================
module shift64_ctrl_barrel32
  import shift_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  op,
  input  logic [4:0]  amount,
  output logic [31:0] result
);

  logic [5:0] w_rot_left;

  // Left distance for the rotate; amount=0 gives 32, and a 32-bit shift
  // by 32 yields zero, so rotate-by-0 returns data unchanged.
  assign w_rot_left = 6'd32 - {1'b0, amount};

  always_comb begin
    result = data;
    case (op)
      SHIFT_SLL: result = data << amount;
      SHIFT_SRL: result = data >> amount;
      SHIFT_SRA: result = 32'($signed(data) >>> amount);
      default:   result = (data >> amount) | (data << w_rot_left);
    endcase
  end

endmodule : shift64_ctrl_barrel32
`default_nettype wire

// File: rtl/shift64_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : shift64_ctrl
// Description: 64-bit SLL/SRL/SRA/ROR sequencer built around a single 32-bit
//              barrel shifter. Three passes (mask M, low word A, high word B),
//              one per cycle, merged with the mask into the 64-bit result.
//              Optional macro SHIFT64_BYPASS_EN: a request whose low five
//              amount bits are zero skips the passes and completes after one
//              edge.
// Ports      : clk                 in  - rising-edge clock
//              reset               in  - asynchronous active-high reset
//              in_valid/in_ready   - request handshake (ready only in IDLE)
//              op[1:0]             in  - 00 SLL, 01 SRL, 10 SRA, 11 ROR
//              amount[5:0]         in  - distance 0..63
//              data_hi/data_lo     in  - operand bits [63:32] / [31:0]
//              out_valid/out_ready - result handshake
//              res_hi/res_lo       out - result bits [63:32] / [31:0]
// Revision   : 1.0 - initial release
// ============================================================================
module shift64_ctrl
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [5:0]  amount,
  input  logic [31:0] data_hi,
  input  logic [31:0] data_lo,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  state_t      r_state;
  logic [1:0]  r_op;
  logic [4:0]  r_k;
  logic [31:0] r_h;
  logic [31:0] r_l;
  logic        r_s;
  logic [31:0] r_m;
  logic [31:0] r_a;

  logic [31:0] w_pre_h;
  logic [31:0] w_pre_l;
  logic        w_right;
  logic [4:0]  w_rot_amt;
  logic [31:0] w_sh_data;
  logic [1:0]  w_sh_op;
  logic [4:0]  w_sh_amt;
  logic [31:0] w_sh_res;
  logic [31:0] w_b;
  logic [31:0] w_fill;
  logic [31:0] w_merge_hi;
  logic [31:0] w_merge_lo;

  // Word pre-swap: distances >= 32 become a whole-word move plus a
  // 0..31 shift by k, so the passes only ever handle k.
  always_comb begin
    w_pre_h = data_hi;
    w_pre_l = data_lo;
    if (amount[5]) begin
      case (op)
        SHIFT_SLL: begin w_pre_h = data_lo;              w_pre_l = 32'd0;   end
        SHIFT_SRL: begin w_pre_h = 32'd0;                w_pre_l = data_hi; end
        SHIFT_SRA: begin w_pre_h = {32{data_hi[31]}};    w_pre_l = data_hi; end
        default:   begin w_pre_h = data_lo;              w_pre_l = data_hi; end
      endcase
    end
  end

  assign w_right = (r_op != SHIFT_SLL);
  // Left shifts are done as a rotate right by (32-k) mod 32.
  assign w_rot_amt = w_right ? r_k : (5'd0 - r_k);

  // Shifter drive: PM builds the mask, PA rotates L, PB rotates H.
  always_comb begin
    w_sh_data = r_l;
    w_sh_op   = SHIFT_ROR;
    w_sh_amt  = w_rot_amt;
    case (r_state)
      S_PM: begin
        w_sh_data = ALL_ONES_32;
        w_sh_op   = w_right ? SHIFT_SRL : SHIFT_SLL;
        w_sh_amt  = r_k;
      end
      S_PB:    w_sh_data = r_h;
      default: w_sh_data = r_l;
    endcase
  end

  shift64_ctrl_barrel32 u_barrel (
    .data   (w_sh_data),
    .op     (w_sh_op),
    .amount (w_sh_amt),
    .result (w_sh_res)
  );

  // B is consumed straight from the shifter during PB.
  assign w_b    = w_sh_res;
  assign w_fill = ((r_op == SHIFT_SRA) && r_s) ? ~r_m : 32'd0;

  always_comb begin
    w_merge_hi = (w_b & r_m) | w_fill;
    w_merge_lo = (r_a & r_m) | (w_b & ~r_m);
    case (r_op)
      SHIFT_SLL: begin
        w_merge_hi = (w_b & r_m) | (r_a & ~r_m);
        w_merge_lo = r_a & r_m;
      end
      SHIFT_ROR: w_merge_hi = (w_b & r_m) | (r_a & ~r_m);
      default:   w_merge_hi = (w_b & r_m) | w_fill;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= 2'd0;
      r_k       <= 5'd0;
      r_h       <= 32'd0;
      r_l       <= 32'd0;
      r_s       <= 1'b0;
      r_m       <= 32'd0;
      r_a       <= 32'd0;
      res_hi    <= 32'd0;
      res_lo    <= 32'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_op     <= op;
            r_k      <= amount[4:0];
            r_h      <= w_pre_h;
            r_l      <= w_pre_l;
            r_s      <= data_hi[31];
            in_ready <= 1'b0;
`ifdef SHIFT64_BYPASS_EN
            if (amount[4:0] == 5'd0) begin
              // Pre-swapped words (incl. the SRA fill word) are the result.
              // out_valid is raised from DONE on the following edge.
              res_hi  <= w_pre_h;
              res_lo  <= w_pre_l;
              r_state <= S_DONE;
            end else begin
              r_state <= S_PM;
            end
`else
            r_state <= S_PM;
`endif
          end
        end
        S_PM: begin
          r_m     <= w_sh_res;
          r_state <= S_PA;
        end
        S_PA: begin
          r_a     <= w_sh_res;
          r_state <= S_PB;
        end
        S_PB: begin
          res_hi    <= w_merge_hi;
          res_lo    <= w_merge_lo;
          out_valid <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          // Entering DONE without out_valid only happens on the bypass path.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule : shift64_ctrl
`default_nettype wire

// File: tb/tb_shift64_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_shift64_ctrl
// Description: Directed self-checking bench for shift64_ctrl. Each scenario
//              task drives requests and compares results, latency and
//              handshake outputs against hand-computed values.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_shift64_ctrl;
  import shift_pkg::*;

`ifdef SHIFT64_BYPASS_EN
  localparam int LAT_K0 = 1;
`else
  localparam int LAT_K0 = 3;
`endif
  localparam int LAT_N = 3;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [5:0]  amount;
  logic [31:0] data_hi;
  logic [31:0] data_lo;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  int n_vec = 0;
  int n_err = 0;

  shift64_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .amount    (amount),
    .data_hi   (data_hi),
    .data_lo   (data_lo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request, wait (bounded) for out_valid, return latency in edges
  // after the accept edge and the 64-bit result, then complete the handshake.
  task automatic do_req(input logic [1:0] o, input logic [5:0] n,
                        input logic [31:0] hi, input logic [31:0] lo,
                        output int lat, output logic [63:0] res);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    op = o; amount = n; data_hi = hi; data_lo = lo; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = {res_hi, res_lo};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++;
    if ({res_hi, res_lo} !== 64'd0) begin n_err++; $display("FAIL reset_res got %h want 0", {res_hi, res_lo}); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_sll();
    int lat; logic [63:0] r;
    do_req(SHIFT_SLL, 6'd1, 32'h0000_0001, 32'h8000_0000, lat, r);
    n_vec++;
    if (lat !== LAT_N) begin n_err++; $display("FAIL sll1_latency got %0d want %0d", lat, LAT_N); end
    n_vec++;
    if (r !== 64'h0000_0003_0000_0000) begin n_err++; $display("FAIL sll1_res got %h want 0000000300000000", r); end
    do_req(SHIFT_SLL, 6'd32, 32'h1234_5678, 32'h9ABC_DEF0, lat, r);
    n_vec++;
    if (lat !== LAT_K0) begin n_err++; $display("FAIL sll32_latency got %0d want %0d", lat, LAT_K0); end
    n_vec++;
    if (r !== 64'h9ABC_DEF0_0000_0000) begin n_err++; $display("FAIL sll32_res got %h want 9abcdef000000000", r); end
  endtask

  task automatic test_right();
    int lat; logic [63:0] r;
    do_req(SHIFT_SRA, 6'd36, 32'h8000_0000, 32'h0000_0000, lat, r);
    n_vec++;
    if (r !== 64'hFFFF_FFFF_F800_0000) begin n_err++; $display("FAIL sra36_res got %h want fffffffff8000000", r); end
    n_vec++;
    if (lat !== LAT_N) begin n_err++; $display("FAIL sra36_latency got %0d want %0d", lat, LAT_N); end
    do_req(SHIFT_SRL, 6'd36, 32'h8000_0000, 32'h0000_0000, lat, r);
    n_vec++;
    if (r !== 64'h0000_0000_0800_0000) begin n_err++; $display("FAIL srl36_res got %h want 0000000008000000", r); end
    do_req(SHIFT_SRL, 6'd63, 32'hFFFF_FFFF, 32'h0000_0000, lat, r);
    n_vec++;
    if (r !== 64'h0000_0000_0000_0001) begin n_err++; $display("FAIL srl63_res got %h want 0000000000000001", r); end
    do_req(SHIFT_SRA, 6'd4, 32'hF000_0000, 32'h0000_0000, lat, r);
    n_vec++;
    if (r !== 64'hFF00_0000_0000_0000) begin n_err++; $display("FAIL sra4_res got %h want ff00000000000000", r); end
  endtask

  task automatic test_ror();
    int lat; logic [63:0] r;
    do_req(SHIFT_ROR, 6'd32, 32'h1234_5678, 32'h9ABC_DEF0, lat, r);
    n_vec++;
    if (r !== 64'h9ABC_DEF0_1234_5678) begin n_err++; $display("FAIL ror32_res got %h want 9abcdef012345678", r); end
    do_req(SHIFT_ROR, 6'd0, 32'h1234_5678, 32'h9ABC_DEF0, lat, r);
    n_vec++;
    if (r !== 64'h1234_5678_9ABC_DEF0) begin n_err++; $display("FAIL ror0_res got %h want 123456789abcdef0", r); end
    n_vec++;
    if (lat !== LAT_K0) begin n_err++; $display("FAIL ror0_latency got %0d want %0d", lat, LAT_K0); end
    do_req(SHIFT_ROR, 6'd4, 32'h1234_5678, 32'h9ABC_DEF0, lat, r);
    n_vec++;
    if (r !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL ror4_res got %h want 0123456789abcdef", r); end
  endtask

  task automatic test_backpressure();
    int lat;
    op = SHIFT_SLL; amount = 6'd1; data_hi = 32'h0000_0001; data_lo = 32'h8000_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    // Keep in_valid high with new operands; they must be ignored until IDLE.
    op = SHIFT_ROR; amount = 6'd4; data_hi = 32'h1234_5678; data_lo = 32'h9ABC_DEF0;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_busy_in_ready got %b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_vec++;
    if (lat !== LAT_N) begin n_err++; $display("FAIL bp_latency got %0d want %0d", lat, LAT_N); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", c, out_valid); end
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_in_ready cycle %0d got %b want 0", c, in_ready); end
      n_vec++;
      if ({res_hi, res_lo} !== 64'h0000_0003_0000_0000) begin
        n_err++; $display("FAIL bp_hold_res cycle %0d got %h want 0000000300000000", c, {res_hi, res_lo});
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    n_vec++;
    if ({res_hi, res_lo} !== 64'h0000_0003_0000_0000) begin
      n_err++; $display("FAIL bp_release_res got %h want 0000000300000000", {res_hi, res_lo});
    end
    // in_valid is still high: the ROR request is accepted on this first IDLE edge.
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept_in_ready got %b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_vec++;
    if (lat !== LAT_N) begin n_err++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT_N); end
    n_vec++;
    if ({res_hi, res_lo} !== 64'h0123_4567_89AB_CDEF) begin
      n_err++; $display("FAIL b2b_res got %h want 0123456789abcdef", {res_hi, res_lo});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] r;
    op = SHIFT_SRL; amount = 6'd5; data_hi = 32'hDEAD_BEEF; data_lo = 32'h0BAD_F00D;
    in_valid = 1'b1;
    @(posedge clk); #1;       // accept -> PM
    in_valid = 1'b0;
    @(posedge clk); #1;       // PM -> PA
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    n_vec++;
    if ({res_hi, res_lo} !== 64'd0) begin n_err++; $display("FAIL midrst_res got %h want 0", {res_hi, res_lo}); end
    @(posedge clk); #1;
    reset = 1'b0;
    do_req(SHIFT_SLL, 6'd1, 32'h0000_0000, 32'h0000_0001, lat, r);
    n_vec++;
    if (r !== 64'h0000_0000_0000_0002) begin n_err++; $display("FAIL midrst_after_res got %h want 0000000000000002", r); end
    n_vec++;
    if (lat !== LAT_N) begin n_err++; $display("FAIL midrst_after_latency got %0d want %0d", lat, LAT_N); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'd0; amount = 6'd0; data_hi = 32'd0; data_lo = 32'd0;
    test_reset();
    test_sll();
    test_right();
    test_ror();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_shift64_ctrl
`default_nettype wire
